mem_master: RTL and testbench

- Bus initiator for the word-addressed synchronous memory block, sitting between the CPU load/store stage and the memory's write/out/address/data pins.
- Accepts one byte, halfword or word load/store at a time on a valid/ready request port and sequences the memory's one-cycle registered-read protocol.
- Performs read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
- Reports misaligned and out-of-range accesses as faults without touching memory.

---
 rtl/mem_master.sv | 202 ++++++++++++++++++++
 tb/tb_mem_master.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// mem_master: bus initiator for the word-addressed synchronous memory.
// Takes one byte/halfword/word load or store at a time. It sequences the
// memory's one-cycle registered read, merges sub-word stores into the old
// word (read-modify-write), and extends sub-word loads. Misaligned or
// out-of-range requests return a fault without any memory cycle.
module mem_master #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_write,
    output logic        mem_out,
    output logic [31:0] mem_address,
    inout  wire  [31:0] mem_data
);

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_BYTES);
    localparam logic [1:0]  SZ_BYTE    = 2'd0;
    localparam logic [1:0]  SZ_HALF    = 2'd1;
    localparam logic [1:0]  SZ_WORD    = 2'd2;
    localparam logic [1:0]  SZ_RSVD    = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Request fields held from acceptance until the response
    logic        write_p0;
    logic [1:0]  size_p0;
    logic        sgn_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic        fault_p0;
    // Old memory word captured in RD_DATA
    logic [31:0] old_p1;

    logic        accept;
    logic        fault_now;
    logic        drive_en;
    logic [31:0] drive_word;
    logic [31:0] word_addr;

    // Move the addressed lane to bit 0, then sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: load_extract = sgn ? {{24{b[7]}}, b}  : {24'd0, b};
            SZ_HALF: load_extract = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: load_extract = word;
        endcase
    endfunction

    // Replace only the addressed lane(s) of the old word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] m;
        m = old;
        case (size)
            SZ_BYTE: m[{lane, 3'b000} +: 8]     = wd[7:0];
            SZ_HALF: m[{lane[1], 4'b0000} +: 16] = wd[15:0];
            default: m = wd;
        endcase
        return m;
    endfunction

    assign accept    = req_valid && req_ready;
    assign word_addr = {addr_p0[31:2], 2'b00};

    // Alignment / range check on the live request, used at acceptance
    always_comb begin
        fault_now = 1'b0;
        case (req_size)
            SZ_HALF: fault_now = req_addr[0];
            SZ_WORD: fault_now = |req_addr[1:0];
            SZ_RSVD: fault_now = 1'b1;
            default: fault_now = 1'b0;
        endcase
        if ({1'b0, req_addr} >= ADDR_LIMIT) begin
            fault_now = 1'b1;
        end
    end

    // State register; reset aborts any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing of the memory protocol
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (fault_now) begin
                        state_d = RESP;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_d = WR_DATA;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: state_d = write_p0 ? WR_DATA : RESP;
            WR_DATA: state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: capture request fields on acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0 <= req_write;
            size_p0  <= req_size;
            sgn_p0   <= req_signed;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            fault_p0 <= fault_now;
        end
    end

    // Stage p1: capture the word the memory drives during RD_DATA
    always_ff @(posedge clk) begin
        if (state_q == RD_DATA) begin
            old_p1 <= mem_data;
        end
    end

    // State-decoded outputs; write strobe and bus drive gated by reset
    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_fault  = 1'b0;
        resp_rdata  = 32'd0;
        mem_write   = 1'b0;
        mem_out     = 1'b0;
        mem_address = 32'd0;
        drive_en    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = rst_n;
            end
            RD_ADDR: begin
                mem_address = word_addr;
            end
            RD_DATA: begin
                mem_address = word_addr;
                mem_out     = 1'b1;
            end
            WR_DATA: begin
                mem_address = word_addr;
                mem_write   = rst_n;
                drive_en    = rst_n;
            end
            RESP: begin
                mem_address = word_addr;
                resp_valid  = 1'b1;
                resp_fault  = fault_p0;
                if (!fault_p0 && !write_p0) begin
                    resp_rdata = load_extract(old_p1, size_p0, addr_p0[1:0], sgn_p0);
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign drive_word = (size_p0 == SZ_WORD) ? wdata_p0
                                             : store_merge(old_p1, wdata_p0, size_p0, addr_p0[1:0]);
    assign mem_data   = drive_en ? drive_word : 32'bz;

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: drives mem_master against a behavioural word memory and
// compares every response with a byte-array reference model.
module tb_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_write;
    logic        mem_out;
    logic [31:0] mem_address;
    wire  [31:0] mem_data;

    logic [31:0] memw [64];
    logic [31:0] buffer;
    logic [7:0]  ref_mem [256];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_master #(.MEM_BYTES(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_write(mem_write), .mem_out(mem_out),
        .mem_address(mem_address), .mem_data(mem_data)
    );

    // Synchronous memory: registered read buffer, write on the same edge
    always @(posedge clk) begin
        if (mem_write) memw[mem_address[7:2]] <= mem_data;
        buffer <= memw[mem_address[7:2]];
    end
    assign mem_data = mem_out ? buffer : 32'bz;

    function automatic logic ref_fault(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd256);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int n;
        longint v;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(a) + i]) << (8 * i));
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a) + i] = wd[8 * i +: 8];
    endtask

    function automatic int exp_lat(input logic w, input logic [1:0] sz, input logic flt);
        if (flt) return 1;
        if (!w) return 3;
        return (sz == 2'd2) ? 2 : 4;
    endfunction

    // Issue one request; lat = negedges after acceptance until resp_valid
    // (-1: no response, -2: never ready). act counts cycles with memory activity.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic flt, output int lat,
                          output int clash, output int act);
        bit ok;
        rd = 32'd0; flt = 1'b0; lat = -1; clash = 0; act = 0; ok = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        for (int k = 0; k < 20; k++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            req_valid = 1'b0; lat = -2;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 12; k++) begin
            if (mem_out && mem_write) clash++;
            if (mem_out || mem_write) act++;
            if (resp_valid) begin
                lat = k; rd = resp_rdata; flt = resp_fault;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({resp_valid, resp_fault, mem_write, mem_out, req_ready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000", {resp_valid, resp_fault, mem_write, mem_out, req_ready});
        end
        checks++;
        if (mem_address !== 32'd0 || resp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_data addr=%h rdata=%h want 0/0", mem_address, resp_rdata);
        end
        req_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_init_mem;
        logic [31:0] rd, wd; logic flt; int lat, cl, act, bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), wd, rd, flt, lat, cl, act);
            ref_store(32'(i * 4), 2'd2, wd);
            if (lat != 2 || flt !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL init_word_stores bad=%0d want=0", bad); end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic flt; int lat, cl, act;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, flt, lat, cl, act);
        ref_store(32'h10, 2'd2, 32'hDEADBEEF);
        checks++;
        if (lat != 2 || flt !== 1'b0 || rd !== 32'd0) begin
            failures++; $display("FAIL word_store lat=%0d fault=%b rdata=%h want 2/0/0", lat, flt, rd);
        end
        do_req(1'b0, 2'd2, 1'b1, 32'h10, $urandom, rd, flt, lat, cl, act);
        checks++;
        if (lat != 3 || flt !== 1'b0) begin failures++; $display("FAIL word_load_lat lat=%0d fault=%b want 3/0", lat, flt); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load_data got=%h want=deadbeef", rd); end
        checks++;
        if (cl != 0) begin failures++; $display("FAIL out_write_overlap got=%0d want=0", cl); end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic flt; int lat, cl, act;
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAAAA80, rd, flt, lat, cl, act);
        ref_store(32'h11, 2'd0, 32'hAAAAAA80);
        checks++;
        if (lat != 4 || flt !== 1'b0 || cl != 0) begin
            failures++; $display("FAIL byte_store lat=%0d fault=%b clash=%0d want 4/0/0", lat, flt, cl);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, flt, lat, cl, act);
        checks++;
        if (rd !== 32'hDEAD80EF) begin failures++; $display("FAIL byte_merge got=%h want=dead80ef", rd); end
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, rd, flt, lat, cl, act);
        checks++;
        if (rd !== 32'hFFFFFF80 || lat != 3) begin failures++; $display("FAIL byte_load_signed got=%h lat=%0d want=ffffff80/3", rd, lat); end
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, rd, flt, lat, cl, act);
        checks++;
        if (rd !== 32'h00000080) begin failures++; $display("FAIL byte_load_unsigned got=%h want=00000080", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic flt; int lat, cl, act;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, flt, lat, cl, act);
        ref_store(32'h10, 2'd2, 32'hDEADBEEF);
        do_req(1'b1, 2'd1, 1'b1, 32'h12, 32'h55551234, rd, flt, lat, cl, act);
        ref_store(32'h12, 2'd1, 32'h55551234);
        checks++;
        if (lat != 4 || flt !== 1'b0) begin failures++; $display("FAIL half_store lat=%0d fault=%b want 4/0", lat, flt); end
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, rd, flt, lat, cl, act);
        checks++;
        if (rd !== 32'h00001234) begin failures++; $display("FAIL half_load got=%h want=00001234", rd); end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, flt, lat, cl, act);
        checks++;
        if (rd !== 32'h1234BEEF) begin failures++; $display("FAIL half_merge got=%h want=1234beef", rd); end
    endtask

    task automatic test_faults;
        logic [31:0] rd; logic flt; int lat, cl, act;
        logic [31:0] fa [5];
        logic [1:0]  fs [5];
        logic        fw [5];
        fa = '{32'h13, 32'h102, 32'h0, 32'h100, 32'h22};
        fs = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
        fw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            do_req(fw[i], fs[i], 1'b1, fa[i], $urandom, rd, flt, lat, cl, act);
            checks++;
            if (flt !== 1'b1 || rd !== 32'd0 || lat != 1 || act != 0) begin
                failures++;
                $display("FAIL fault_%0d fault=%b rdata=%h lat=%0d act=%0d want 1/0/1/0", i, flt, rd, lat, act);
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd; logic flt; int lat, cl, act;
        bit seen;
        logic [31:0] old24;
        seen = 0;
        // Sub-word store aborted in RD_DATA
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h21; req_wdata = {24'd0, ~ref_mem[8'h21]};
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL abort1_ready got=%b want=1", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        seen = seen | resp_valid;
        @(negedge clk);
        checks++;
        if (mem_out !== 1'b1 || mem_address !== 32'h20) begin
            failures++; $display("FAIL abort1_in_rd_data out=%b addr=%h want 1/00000020", mem_out, mem_address);
        end
        rst_n = 1'b0;
        @(negedge clk);
        seen = seen | resp_valid;
        checks++;
        if ({resp_valid, resp_fault, mem_write, mem_out, req_ready} !== 5'b0 || mem_address !== 32'd0 || resp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL abort1_outputs ctrl=%b addr=%h rdata=%h want 0", {resp_valid, resp_fault, mem_write, mem_out, req_ready}, mem_address, resp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        seen = seen | resp_valid;
        checks++;
        if (req_ready !== 1'b1 || seen) begin failures++; $display("FAIL abort1_release ready=%b resp_seen=%0d want 1/0", req_ready, seen); end
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, rd, flt, lat, cl, act);
        checks++;
        if (rd !== ref_load(32'h20, 2'd2, 1'b0)) begin failures++; $display("FAIL abort1_unchanged got=%h want=%h", rd, ref_load(32'h20, 2'd2, 1'b0)); end
        // Word store aborted in WR_DATA
        old24 = ref_load(32'h24, 2'd2, 1'b0);
        seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h24; req_wdata = ~old24;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (mem_write !== 1'b1) begin failures++; $display("FAIL abort2_in_wr_data write=%b want=1", mem_write); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0) begin failures++; $display("FAIL abort2_write_gated got=%b want=0", mem_write); end
        @(negedge clk);
        seen = seen | resp_valid;
        checks++;
        if ({resp_valid, resp_fault, mem_write, mem_out, req_ready} !== 5'b0 || mem_address !== 32'd0) begin
            failures++; $display("FAIL abort2_outputs ctrl=%b addr=%h want 0", {resp_valid, resp_fault, mem_write, mem_out, req_ready}, mem_address);
        end
        rst_n = 1'b1;
        @(negedge clk);
        seen = seen | resp_valid;
        checks++;
        if (req_ready !== 1'b1 || seen) begin failures++; $display("FAIL abort2_release ready=%b resp_seen=%0d want 1/0", req_ready, seen); end
        do_req(1'b0, 2'd2, 1'b0, 32'h24, 32'd0, rd, flt, lat, cl, act);
        checks++;
        if (rd !== old24) begin failures++; $display("FAIL abort2_unchanged got=%h want=%h", rd, old24); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals [3];
        int acc_cyc [6];
        int nacc, nresp, nwrite, nready, clash, bad;
        bit pend;
        logic [31:0] rd; logic flt; int lat, cl, act;
        for (int i = 0; i < 3; i++) vals[i] = $urandom;
        nacc = 0; nresp = 0; nwrite = 0; nready = 0; clash = 0; bad = 0; pend = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'hFC; req_wdata = vals[0];
        for (int cyc = 0; cyc < 80 && nresp < 6; cyc++) begin
            if (pend) begin
                acc_cyc[nacc] = cyc; nacc++; pend = 0;
                if (nacc < 6) begin
                    req_write = (nacc % 2 == 0); req_wdata = vals[nacc / 2]; req_signed = 1'($urandom);
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (mem_write) nwrite++;
            if (mem_write && mem_out) clash++;
            if (resp_valid) begin
                if (resp_fault !== 1'b0) bad++;
                if (nresp % 2 == 1 && resp_rdata !== vals[nresp / 2]) bad++;
                if (nresp % 2 == 0 && resp_rdata !== 32'd0) bad++;
                if (req_ready) bad++;
                nresp++;
            end
            if (req_valid && req_ready) begin pend = 1; nready++; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        ref_store(32'hFC, 2'd2, vals[2]);
        checks++;
        if (nacc != 6 || nready != 6 || nresp != 6) begin
            failures++; $display("FAIL b2b_counts acc=%0d ready=%0d resp=%0d want 6/6/6", nacc, nready, nresp);
        end
        checks++;
        if (nwrite != 3 || clash != 0 || bad != 0) begin
            failures++; $display("FAIL b2b_traffic writes=%0d clash=%0d bad=%0d want 3/0/0", nwrite, clash, bad);
        end
        for (int i = 0; i + 1 < nacc && i < 5; i++) begin
            checks++;
            if (acc_cyc[i + 1] - acc_cyc[i] != ((i % 2 == 0) ? 3 : 4)) begin
                failures++; $display("FAIL b2b_spacing_%0d got=%0d want=%0d", i, acc_cyc[i + 1] - acc_cyc[i], (i % 2 == 0) ? 3 : 4);
            end
        end
        do_req(1'b0, 2'd2, 1'b0, 32'hFC, 32'd0, rd, flt, lat, cl, act);
        checks++;
        if (rd !== vals[2]) begin failures++; $display("FAIL b2b_final got=%h want=%h", rd, vals[2]); end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, wd, erd; logic flt, w, sg, ef; logic [1:0] sz; int lat, cl, act;
        for (int n = 0; n < 80; n++) begin
            a = 32'($urandom_range(0, 279));
            sz = 2'($urandom_range(0, 3));
            w = 1'($urandom); sg = 1'($urandom); wd = $urandom;
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 15) == 0) a = $urandom;
            ef = ref_fault(a, sz);
            erd = (ef || w) ? 32'd0 : ref_load(a, sz, sg);
            do_req(w, sz, sg, a, wd, rd, flt, lat, cl, act);
            if (!ef && w) ref_store(a, sz, wd);
            checks++;
            if (flt !== ef || rd !== erd || lat != exp_lat(w, sz, ef) || cl != 0) begin
                failures++;
                $display("FAIL rand_%0d w=%b sz=%0d a=%h fault=%b/%b rdata=%h/%h lat=%0d/%0d clash=%0d",
                         n, w, sz, a, flt, ef, rd, erd, lat, exp_lat(w, sz, ef), cl);
            end
        end
    endtask

    task automatic test_mem_image;
        logic [31:0] e;
        int bad;
        bad = 0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            e = {ref_mem[4 * i + 3], ref_mem[4 * i + 2], ref_mem[4 * i + 1], ref_mem[4 * i]};
            if (memw[i] !== e) begin
                bad++;
                if (bad < 5) $display("FAIL mem_image word=%0d got=%h want=%h", i, memw[i], e);
            end
        end
        checks++;
        if (bad != 0) failures++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_mem();
        test_word();
        test_byte();
        test_half();
        test_faults();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_mem_image();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
